// File: rtl/binary_pkg.sv
// Shared types and helpers for the binary popcount accumulator and its
// neighbours in the binarized linear layer.
package binary_pkg;

    // Accumulator control states: gathering beats, or holding a result.
    typedef enum logic [0:0] {
        ACCUM  = 1'b0,
        OUTPUT = 1'b1
    } state_t;

    // Width of a signed bipolar dot product over in_size*num_beats terms.
    // Needs to hold -N..+N.
    function automatic int unsigned out_width(input int unsigned in_size,
                                              input int unsigned num_beats);
        return $clog2(in_size * num_beats + 1) + 1;
    endfunction

endpackage

// File: rtl/binary_popcount.sv
// Combinational popcount of a 1-bit unpacked vector, built as a balanced
// binary adder tree. Inputs are padded with zeros up to a power of two.
module binary_popcount #(
    parameter int unsigned IN_SIZE = 4,
    localparam int unsigned COUNT_W = $clog2(IN_SIZE + 1)
) (
    input  logic               data_in [IN_SIZE],
    output logic [COUNT_W-1:0] count
);

    localparam int unsigned LEVELS = $clog2(IN_SIZE);
    localparam int unsigned LEAVES = 1 << LEVELS;

    // Heap-indexed tree: node[1] is the root, leaves at LEAVES..2*LEAVES-1.
    // No partial sum can exceed IN_SIZE, so COUNT_W bits suffice everywhere.
    logic [COUNT_W-1:0] node [1:2*LEAVES-1];

    genvar g;

    for (g = 0; g < LEAVES; g++) begin : g_leaf
        if (g < IN_SIZE) begin : g_used
            assign node[LEAVES+g] = COUNT_W'(data_in[g]);
        end else begin : g_pad
            assign node[LEAVES+g] = '0;
        end
    end

    for (g = 1; g < LEAVES; g++) begin : g_sum
        assign node[g] = node[2*g] + node[2*g+1];
    end

    assign count = node[1];

endmodule

// File: rtl/binary_popcount_accumulator.sv
// Popcount accumulator: sums the popcounts of NUM_BEATS product vectors and
// emits one dot product per group over a valid/ready stream.
// Build option BINARY_POPCOUNT_RAW_EN: when defined, data_out carries the raw
// popcount total (0..N, unsigned); otherwise the bipolar value 2*total-N.
module binary_popcount_accumulator
    import binary_pkg::*;
#(
    parameter int unsigned IN_SIZE   = 4,
    parameter int unsigned NUM_BEATS = 4,
    localparam int unsigned OUT_WIDTH = out_width(IN_SIZE, NUM_BEATS)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        data_in [IN_SIZE],
    input  logic                        data_in_valid,
    output logic                        data_in_ready,
    output logic signed [OUT_WIDTH-1:0] data_out,
    output logic                        data_out_valid,
    input  logic                        data_out_ready
);

    localparam int unsigned N     = IN_SIZE * NUM_BEATS;
    localparam int unsigned POP_W = $clog2(IN_SIZE + 1);
    localparam int unsigned ACC_W = $clog2(N + 1);
    localparam int unsigned CNT_W = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NUM_BEATS - 1);

    state_t               state;
    logic [CNT_W-1:0]     beat_cnt;
    logic [ACC_W-1:0]     acc;
    logic [POP_W-1:0]     pop;
    logic [ACC_W-1:0]     total;
    logic [OUT_WIDTH-1:0] result;
    logic                 in_fire;
    logic                 out_fire;
    logic                 last_beat;

    binary_popcount #(
        .IN_SIZE(IN_SIZE)
    ) u_popcount (
        .data_in(data_in),
        .count  (pop)
    );

    // Input is always open while accumulating; while a result is pending it
    // only opens when that result is being taken this same cycle.
    always_comb begin
        data_in_ready = (state == ACCUM) ? 1'b1 : data_out_ready;
        in_fire       = data_in_valid && data_in_ready;
        out_fire      = data_out_valid && data_out_ready;
        last_beat     = (beat_cnt == LAST_BEAT);
        total         = acc + ACC_W'(pop);
    end

    // Result formatting for the completed group.
    always_comb begin
`ifdef BINARY_POPCOUNT_RAW_EN
        result = OUT_WIDTH'(total);
`else
        // 2*total-N computed modulo 2^OUT_WIDTH; the true value lies in
        // -N..+N, so the wrapped intermediate still yields the exact result.
        result = {total, 1'b0} - OUT_WIDTH'(N);
`endif
    end

    // Control FSM with counter, accumulator and registered output.
    // acc and beat_cnt are already zero in OUTPUT, so a beat accepted there
    // goes through the same path as in ACCUM and naturally starts a new
    // group (or, with NUM_BEATS==1, completes one and stays in OUTPUT).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= ACCUM;
            beat_cnt       <= '0;
            acc            <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    data_out_valid <= 1'b0;
                end
                OUTPUT: begin
                    if (out_fire && !in_fire) begin
                        state          <= ACCUM;
                        data_out_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= ACCUM;
                    data_out_valid <= 1'b0;
                end
            endcase

            if (in_fire) begin
                if (last_beat) begin
                    data_out       <= result;
                    data_out_valid <= 1'b1;
                    acc            <= '0;
                    beat_cnt       <= '0;
                    state          <= OUTPUT;
                end else begin
                    acc            <= total;
                    beat_cnt       <= beat_cnt + CNT_W'(1);
                    data_out_valid <= 1'b0;
                    state          <= ACCUM;
                end
            end
        end
    end

endmodule

// File: tb/tb_binary_popcount_accumulator.sv
// Self-checking bench for binary_popcount_accumulator: directed scenarios plus
// randomized streaming against a queue-based group model.
module tb_binary_popcount_accumulator;

    localparam int unsigned IN_SIZE   = 4;
    localparam int unsigned NUM_BEATS = 4;
    localparam int unsigned N         = IN_SIZE * NUM_BEATS;
    localparam int unsigned OUT_WIDTH = $clog2(N + 1) + 1;

    logic                        clk = 1'b0;
    logic                        rst = 1'b0;
    logic [IN_SIZE-1:0]          din_vec = '0;
    logic                        data_in [IN_SIZE];
    logic                        data_in_valid = 1'b0;
    logic                        data_in_ready;
    logic signed [OUT_WIDTH-1:0] data_out;
    logic                        data_out_valid;
    logic                        data_out_ready = 1'b1;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    int q[$];
    int m_sum     = 0;
    int m_beats   = 0;
    int m_results = 0;

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < IN_SIZE; i++) data_in[i] = din_vec[i];
    end

    binary_popcount_accumulator #(
        .IN_SIZE  (IN_SIZE),
        .NUM_BEATS(NUM_BEATS)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .data_in       (data_in),
        .data_in_valid (data_in_valid),
        .data_in_ready (data_in_ready),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready)
    );

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int expected_of(input int total);
`ifdef BINARY_POPCOUNT_RAW_EN
        return total;
`else
        return 2 * total - int'(N);
`endif
    endfunction

    // Scoreboard: at each falling edge, handshakes that will complete on the
    // next rising edge are decided; a result is owed exactly while q is non-empty.
    always @(negedge clk) begin
        if (!rst) begin
            q.delete();
            m_sum   = 0;
            m_beats = 0;
        end else begin
            check("sb_valid", data_out_valid, q.size() != 0);
            check("sb_in_ready", data_in_ready, (q.size() == 0) || data_out_ready);
            if (data_out_valid && q.size() != 0) check("sb_data", data_out, q[0]);
            if (data_out_valid && data_out_ready && q.size() != 0) begin
                void'(q.pop_front());
                m_results++;
            end
            if (data_in_valid && data_in_ready) begin
                m_sum += $countones(din_vec);
                m_beats++;
                if (m_beats == NUM_BEATS) begin
                    q.push_back(expected_of(m_sum));
                    m_sum   = 0;
                    m_beats = 0;
                end
            end
        end
    end

    // Offer one beat and return just after the rising edge that accepts it.
    // data_in_valid stays high so back-to-back calls have no bubble.
    task automatic send_beat(input logic [IN_SIZE-1:0] v);
        bit ok = 1'b0;
        din_vec       = v;
        data_in_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = data_in_ready;
        end
        check("beat_accepted", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        data_in_valid = 1'b0;
    endtask

    task automatic expect_result(input string tag, input int exp);
        bit seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            seen = data_out_valid;
        end
        check({tag, "_valid"}, seen, 1);
        if (seen) check(tag, data_out, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held with random inputs
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            din_vec        = IN_SIZE'($urandom);
            data_in_valid  = 1'($urandom);
            data_out_ready = 1'($urandom);
            @(negedge clk);
            check("rst_valid", data_out_valid, 0);
            check("rst_data", data_out, 0);
        end
        @(posedge clk);
        #1;
        rst            = 1'b1;
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ready", data_in_ready, 1);
        @(posedge clk);
        #1;

        // All ones -> +16 (raw 16)
        repeat (NUM_BEATS) send_beat(4'b1111);
        idle();
        expect_result("all_ones", expected_of(16));

        // Mixed, pop 9 -> +2 (raw 9)
        send_beat(4'b1010);
        send_beat(4'b1111);
        send_beat(4'b0000);
        send_beat(4'b0111);
        idle();
`ifdef BINARY_POPCOUNT_RAW_EN
        expect_result("mixed", 9);
`else
        expect_result("mixed", 2);
`endif

        // All zeros -> -16 (raw 0)
        repeat (NUM_BEATS) send_beat(4'b0000);
        idle();
        expect_result("all_zeros", expected_of(0));

        // Backpressure: result stalled 5 cycles while a beat is offered
        data_out_ready = 1'b0;
        repeat (NUM_BEATS) send_beat(4'b0101);
        din_vec = 4'b1100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", data_out_valid, 1);
            check("bp_in_ready", data_in_ready, 0);
            check("bp_data", data_out, expected_of(8));
            @(posedge clk);
            #1;
        end
        data_out_ready = 1'b1;
        send_beat(4'b1100);
        repeat (NUM_BEATS - 1) send_beat(4'b1111);
        idle();
        expect_result("bp_next_group", expected_of(14));

        // Reset mid-group discards two accepted beats
        send_beat(4'b1111);
        send_beat(4'b1111);
        idle();
        #2;
        rst = 1'b0;
        #1;
        check("midrst_valid", data_out_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (NUM_BEATS) send_beat(4'b0001);
        idle();
`ifdef BINARY_POPCOUNT_RAW_EN
        expect_result("midrst_group", 4);
`else
        expect_result("midrst_group", -8);
`endif

        // Streaming: valid held high, random ready, then mixed valid
        m_results = 0;
        for (int i = 0; i < 120; i++) begin
            din_vec        = IN_SIZE'($urandom);
            data_in_valid  = (i < 60) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            data_out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        data_in_valid  = 1'b0;
        data_out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        @(negedge clk);
        check("stream_drained", q.size(), 0);
        check("stream_groups", m_results >= 3, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
